mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 Inputs from EX/MEM register SHALL be: mem_we 1 (reg write), mem_rd 5, mem_pc 32, mem_ALU_out 32 (address/result), mem_DataB 32 (store data), mem_read 1, mem_write 1, mem_funct3 3.
REQ-003 Data-memory port SHALL be: dmem_req out 1, dmem_wr out 1, dmem_addr out 32 (word-aligned), dmem_be out 4, dmem_wdata out 32, dmem_ready in 1, dmem_rdata in 32.
REQ-004 Outputs to WB SHALL be: wb_we out 1, wb_rd out 5, wb_data out 32, wb_pc out 32, all registered.
REQ-005 Control outputs SHALL be: stall_req out 1 (to stall controller, MEM bit), lsu_err out 1 (registered, one-cycle pulse).

Function
REQ-006 The FSM SHALL have states IDLE and REQ.
REQ-007 Memory op = mem_read XOR mem_write; mem_read AND mem_write SHALL be an error.
REQ-008 Error in IDLE SHALL be: misaligned (funct3 001/101 with addr[0]=1; 010 with addr[1:0]!=0), illegal funct3 (011,110,111; or 100/101 with mem_write), or both read and write.
REQ-009 IDLE, error: lsu_err=1 next cycle, wb_we=0, no request, no stall, stay IDLE.
REQ-010 IDLE, valid memory op: latch addr, be, wdata, rd, pc, we, funct3, byte offset; go REQ; stall_req=1 combinationally this cycle.
REQ-011 IDLE, no memory op: wb regs capture mem_we, mem_rd, mem_ALU_out, mem_pc (1-cycle latency).
REQ-012 REQ: dmem_req=1 with latched address/be/wdata held stable until dmem_ready sampled high.
REQ-013 REQ with dmem_ready=0: stall_req=1, wb_we=0 (bubble).
REQ-014 REQ with dmem_ready=1: stall_req=0; load captures extracted dmem_rdata into wb_data, wb_we=latched we; store writes wb_we=0; return to IDLE.
REQ-015 Minimum load/store latency SHALL be 2 cycles in MEM; no back-to-back accept without passing IDLE.
REQ-016 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_wr=1 for stores only.
REQ-017 Store lanes: SB be=4'b0001<<addr[1:0], byte replicated x4; SH be=0011 (addr[1]=0) or 1100, half replicated x2; SW be=1111.
REQ-018 Load extract: LB/LBU byte at offset sign/zero-extended; LH/LHU half at addr[1] sign/zero-extended; LW full word.
REQ-019 Loads SHALL drive dmem_be=1111; read data masking done internally.
REQ-020 dmem_req, dmem_wr SHALL be 0 in IDLE.
REQ-021 Upstream inputs SHALL be ignored while in REQ (EX/MEM held by stall_req).

Reset
REQ-022 rst SHALL force state IDLE and wb_we=0, wb_rd=0, wb_data=0, wb_pc=0, lsu_err=0, all latched request registers 0.
REQ-023 rst asserted in REQ SHALL abandon the access; dmem_req=0 from the next cycle; a late dmem_ready SHALL be ignored.
REQ-024 stall_req SHALL be 0 in the cycle after reset release unless IDLE accepts a memory op.

Structure
REQ-025 Package lsu_pkg SHALL hold funct3 constants (LB..LHU, SB..SW) and the state enum.
REQ-026 Sub-module lsu_align SHALL be purely combinational: store lane/be generation and load extraction.
REQ-027 RTL SHALL contain no latches; all outputs except stall_req, dmem_* SHALL be flops.

Verification
REQ-028 SW addr 0x100, data 0xDEADBEEF, ready after 3 cycles -> dmem_be=1111, stall_req high 3 cycles, wb_we=0.
REQ-029 LB addr 0x103, rdata 0x80FFFFFF, ready immediately -> wb_data=0xFFFFFF80, wb_we=1, total 2 cycles.
REQ-030 LHU addr 0x102, rdata 0xBEEF1234 -> wb_data=0x0000BEEF; SH addr 0x102 data 0x1234 -> be=1100, wdata=0x12341234.
REQ-031 LW addr 0x101 -> lsu_err pulse 1 cycle, no dmem_req, wb_we=0, stall_req=0.
REQ-032 Reset during REQ with dmem_ready low -> next cycle IDLE, dmem_req=0, all wb outputs 0.
REQ-033 ALU op (mem_read=mem_write=0) rd=5 result 0x42 -> next cycle wb_we=1, wb_rd=5, wb_data=0x42.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// the controller state type and the access legality check.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } lsu_state_e;

   // Flags an access that must never reach memory: simultaneous read and write,
   // a misaligned halfword/word, or a funct3 that has no meaning for the direction.
   function automatic logic lsu_bad_access(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (rd && wr) begin
         bad = 1'b1;
      end else if (rd || wr) begin
         case (f3)
            F3_LB:   bad = 1'b0;
            F3_LH:   bad = off[0];
            F3_LW:   bad = (off != 2'b00);
            F3_LBU:  bad = wr;
            F3_LHU:  bad = wr | off[0];
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and data
// replication on the way out, load lane extraction and extension on the way in.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Replicate narrow store data into every lane so memory only needs the byte enables.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3)
         F3_SB: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_SH: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   // Pick the addressed byte/half out of the returned word and extend it.
   always_comb begin
      ld_byte   = 8'h00;
      ld_half   = 16'h0000;
      ld_result = ld_rdata;
      case (ld_off)
         2'd0:    ld_byte = ld_rdata[7:0];
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         default: ld_byte = ld_rdata[31:24];
      endcase
      ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_funct3)
         F3_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_result = {24'h000000, ld_byte};
         F3_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
         F3_LHU:  ld_result = {16'h0000, ld_half};
         default: ld_result = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts one access from EX/MEM, holds it on the
// data-memory port until ready, and hands results to WB through registers.
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_ALU_out,
   input  logic [31:0] mem_DataB,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_funct3,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] wb_pc,
   output logic        stall_req,
   output logic        lsu_err
);

   lsu_state_e  state, state_nxt;

   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic [31:0] req_pc;
   logic        req_we;
   logic        req_wr;
   logic [2:0]  req_funct3;
   logic [1:0]  req_off;

   logic        mem_op;
   logic        bad_access;
   logic        accept;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_result;

   assign mem_op     = mem_read ^ mem_write;
   assign bad_access = lsu_bad_access(mem_read, mem_write, mem_funct3, mem_ALU_out[1:0]);

   assign dmem_addr  = req_addr;
   assign dmem_be    = req_be;
   assign dmem_wdata = req_wdata;

   lsu_align u_align (
      .st_funct3 (mem_funct3),
      .st_off    (mem_ALU_out[1:0]),
      .st_data   (mem_DataB),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (req_funct3),
      .ld_off    (req_off),
      .ld_rdata  (dmem_rdata),
      .ld_result (ld_result)
   );

   // Decide acceptance and drive the memory handshake and stall from the current state.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      stall_req = 1'b0;
      dmem_req  = 1'b0;
      dmem_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !bad_access) begin
               accept    = 1'b1;
               stall_req = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            dmem_req  = 1'b1;
            dmem_wr   = req_wr;
            stall_req = !dmem_ready;
            if (dmem_ready) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Controller state; reset abandons any outstanding access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the access once at acceptance so the memory port stays stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr   <= 32'h0;
         req_be     <= 4'h0;
         req_wdata  <= 32'h0;
         req_rd     <= 5'h0;
         req_pc     <= 32'h0;
         req_we     <= 1'b0;
         req_wr     <= 1'b0;
         req_funct3 <= 3'h0;
         req_off    <= 2'h0;
      end else if (accept) begin
         req_addr   <= {mem_ALU_out[31:2], 2'b00};
         req_be     <= mem_write ? st_be : 4'b1111;
         req_wdata  <= mem_write ? st_wdata : 32'h0;
         req_rd     <= mem_rd;
         req_pc     <= mem_pc;
         req_we     <= mem_we;
         req_wr     <= mem_write;
         req_funct3 <= mem_funct3;
         req_off    <= mem_ALU_out[1:0];
      end
   end

   // Writeback registers and error pulse: ALU results pass straight through,
   // memory ops insert bubbles until the load data (or store completion) arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we   <= 1'b0;
         wb_rd   <= 5'h0;
         wb_data <= 32'h0;
         wb_pc   <= 32'h0;
         lsu_err <= 1'b0;
      end else begin
         lsu_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bad_access) begin
                  lsu_err <= 1'b1;
                  wb_we   <= 1'b0;
               end else if (mem_op) begin
                  wb_we   <= 1'b0;
               end else begin
                  wb_we   <= mem_we;
                  wb_rd   <= mem_rd;
                  wb_data <= mem_ALU_out;
                  wb_pc   <= mem_pc;
               end
            end
            REQ: begin
               if (dmem_ready) begin
                  wb_we <= req_wr ? 1'b0 : req_we;
                  wb_rd <= req_rd;
                  wb_pc <= req_pc;
                  if (!req_wr) begin
                     wb_data <= ld_result;
                  end
               end else begin
                  wb_we <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_we;
   logic [4:0]  mem_rd;
   logic [31:0] mem_pc;
   logic [31:0] mem_ALU_out;
   logic [31:0] mem_DataB;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_funct3;
   logic        dmem_req;
   logic        dmem_wr;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        stall_req;
   logic        lsu_err;

   int checks   = 0;
   int failures = 0;

   // Model: one outstanding transaction plus the expected writeback registers.
   bit          m_known = 1'b0;
   bit          m_busy  = 1'b0;
   logic [31:0] m_addr, m_data, m_pc;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd;
   logic        m_we, m_store;
   logic        e_wb_we = 1'b0;
   logic        e_err   = 1'b0;
   logic [4:0]  e_wb_rd = 5'h0;
   logic [31:0] e_wb_data = 32'h0;
   logic [31:0] e_wb_pc = 32'h0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk         (clk),
      .rst         (rst),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_pc      (mem_pc),
      .mem_ALU_out (mem_ALU_out),
      .mem_DataB   (mem_DataB),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_funct3  (mem_funct3),
      .dmem_req    (dmem_req),
      .dmem_wr     (dmem_wr),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_ready  (dmem_ready),
      .dmem_rdata  (dmem_rdata),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_pc       (wb_pc),
      .stall_req   (stall_req),
      .lsu_err     (lsu_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit model_err(input logic r, input logic w, input logic [2:0] f3,
                                    input logic [31:0] a);
      if (r && w) return 1'b1;
      if (!r && !w) return 1'b0;
      if (f3 == 3'd0) return 1'b0;
      if (f3 == 3'd1) return a[0];
      if (f3 == 3'd2) return a[1:0] != 2'b00;
      if (f3 == 3'd4) return w;
      if (f3 == 3'd5) return w || a[0];
      return 1'b1;
   endfunction

   function automatic logic [3:0] exp_be(input logic store, input logic [2:0] f3,
                                         input logic [1:0] off);
      if (!store) return 4'hF;
      if (f3 == 3'd0) return 4'b0001 << off;
      if (f3 == 3'd1) return 4'b0011 << (off & 2'b10);
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return {24'h0, d[7:0]} * 32'h01010101;
      if (f3 == 3'd1) return {16'h0, d[15:0]} * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] s;
      s = rdata >> (8 * off);
      if (f3 == 3'd0) return 32'($signed(s[7:0]));
      if (f3 == 3'd4) return {24'h0, s[7:0]};
      if (f3 == 3'd1) return 32'($signed(s[15:0]));
      if (f3 == 3'd5) return {16'h0, s[15:0]};
      return rdata;
   endfunction

   task automatic applyStimulus(input logic r, input logic rdv, input logic wr, input logic we,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] rd,
                                input logic [31:0] pc, input logic ready,
                                input logic [31:0] rdata);
      @(negedge clk);
      rst         = r;
      mem_read    = rdv;
      mem_write   = wr;
      mem_we      = we;
      mem_funct3  = f3;
      mem_ALU_out = addr;
      mem_DataB   = data;
      mem_rd      = rd;
      mem_pc      = pc;
      dmem_ready  = ready;
      dmem_rdata  = rdata;
      #1;
   endtask

   // Compare every observable output with what the model says this cycle.
   task automatic checkOutput();
      logic exp_stall;
      if (!m_known) return;
      if (m_busy) exp_stall = !dmem_ready;
      else        exp_stall = (mem_read ^ mem_write) && !model_err(mem_read, mem_write, mem_funct3, mem_ALU_out);
      chk("stall_req", stall_req, exp_stall);
      chk("dmem_req", dmem_req, m_busy);
      chk("dmem_wr", dmem_wr, m_busy && m_store);
      if (m_busy) begin
         chk("dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
         chk("dmem_be", dmem_be, exp_be(m_store, m_f3, m_addr[1:0]));
         if (m_store) chk("dmem_wdata", dmem_wdata, exp_wdata(m_f3, m_data));
      end
      chk("wb_we", wb_we, e_wb_we);
      chk("lsu_err", lsu_err, e_err);
      if (e_wb_we) begin
         chk("wb_rd", wb_rd, e_wb_rd);
         chk("wb_data", wb_data, e_wb_data);
         chk("wb_pc", wb_pc, e_wb_pc);
      end
   endtask

   // Advance the model across the coming clock edge using this cycle's inputs.
   task automatic modelAdvance();
      if (rst) begin
         m_known = 1'b1; m_busy = 1'b0;
         e_wb_we = 1'b0; e_err = 1'b0; e_wb_rd = 5'h0; e_wb_data = 32'h0; e_wb_pc = 32'h0;
         return;
      end
      if (!m_known) return;
      e_err = 1'b0;
      if (m_busy) begin
         if (dmem_ready) begin
            m_busy = 1'b0;
            if (m_store) begin
               e_wb_we = 1'b0;
            end else begin
               e_wb_we   = m_we;
               e_wb_rd   = m_rd;
               e_wb_pc   = m_pc;
               e_wb_data = exp_load(m_f3, m_addr[1:0], dmem_rdata);
            end
         end else begin
            e_wb_we = 1'b0;
         end
      end else if (model_err(mem_read, mem_write, mem_funct3, mem_ALU_out)) begin
         e_err = 1'b1; e_wb_we = 1'b0;
      end else if (mem_read || mem_write) begin
         m_busy = 1'b1; m_addr = mem_ALU_out; m_data = mem_DataB; m_f3 = mem_funct3;
         m_rd = mem_rd; m_pc = mem_pc; m_we = mem_we; m_store = mem_write;
         e_wb_we = 1'b0;
      end else begin
         e_wb_we = mem_we; e_wb_rd = mem_rd; e_wb_data = mem_ALU_out; e_wb_pc = mem_pc;
      end
   endtask

   task automatic runCycle(input logic r, input logic rdv, input logic wr, input logic we,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd,
                           input logic [31:0] pc, input logic ready,
                           input logic [31:0] rdata);
      applyStimulus(r, rdv, wr, we, f3, addr, data, rd, pc, ready, rdata);
      checkOutput();
      modelAdvance();
   endtask

   task automatic runIdle(input logic ready, input logic [31:0] rdata);
      runCycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, ready, rdata);
   endtask

   // Directed scenarios with hand-computed values, then randomized traffic.
   initial begin
      int stall_cnt;
      logic [2:0] ld_codes [5];
      ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      runCycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
      runCycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);

      // reset state
      runIdle(1'b0, 32'h0);
      chk("rst_wb_we", wb_we, 1'b0);
      chk("rst_wb_rd", wb_rd, 5'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_pc", wb_pc, 32'h0);
      chk("rst_lsu_err", lsu_err, 1'b0);
      chk("rst_stall", stall_req, 1'b0);

      // ALU pass-through
      runCycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h42, 32'h0, 5'd5, 32'h10, 1'b0, 32'h0);
      runIdle(1'b0, 32'h0);
      chk("alu_wb_we", wb_we, 1'b1);
      chk("alu_wb_rd", wb_rd, 5'd5);
      chk("alu_wb_data", wb_data, 32'h42);

      // SW with ready on the third cycle
      stall_cnt = 0;
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 32'h20, 1'b0, 32'h0);
      chk("sw_accept_noreq", dmem_req, 1'b0);
      stall_cnt += int'(stall_req);
      runIdle(1'b0, 32'h0);
      chk("sw_be", dmem_be, 4'hF);
      chk("sw_addr", dmem_addr, 32'h100);
      chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw_dmem_wr", dmem_wr, 1'b1);
      stall_cnt += int'(stall_req);
      runIdle(1'b0, 32'h0);
      stall_cnt += int'(stall_req);
      runIdle(1'b1, 32'h0);
      stall_cnt += int'(stall_req);
      chk("sw_stall_cycles", stall_cnt, 3);
      runIdle(1'b0, 32'h0);
      chk("sw_wb_we", wb_we, 1'b0);
      chk("sw_done_req", dmem_req, 1'b0);

      // LB at offset 3, ready immediately
      stall_cnt = 0;
      runCycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 5'd9, 32'h40, 1'b0, 32'h0);
      stall_cnt += int'(stall_req);
      runIdle(1'b1, 32'h80FFFFFF);
      stall_cnt += int'(stall_req);
      chk("lb_stall_cycles", stall_cnt, 1);
      runIdle(1'b0, 32'h0);
      chk("lb_wb_data", wb_data, 32'hFFFFFF80);
      chk("lb_wb_we", wb_we, 1'b1);
      chk("lb_wb_rd", wb_rd, 5'd9);

      // LHU upper half
      runCycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 32'h102, 32'h0, 5'd3, 32'h44, 1'b0, 32'h0);
      runIdle(1'b1, 32'hBEEF1234);
      runIdle(1'b0, 32'h0);
      chk("lhu_wb_data", wb_data, 32'h0000BEEF);

      // SH upper half
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h102, 32'h00001234, 5'd0, 32'h48, 1'b0, 32'h0);
      runIdle(1'b1, 32'h0);
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'h12341234);

      // misaligned LW
      runCycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h101, 32'h0, 5'd4, 32'h4C, 1'b1, 32'h0);
      chk("lw_mis_stall", stall_req, 1'b0);
      runIdle(1'b0, 32'h0);
      chk("lw_mis_err", lsu_err, 1'b1);
      chk("lw_mis_noreq", dmem_req, 1'b0);
      chk("lw_mis_wb_we", wb_we, 1'b0);
      runIdle(1'b0, 32'h0);
      chk("lw_mis_err_pulse", lsu_err, 1'b0);

      // reset while a load is waiting
      runCycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h200, 32'h0, 5'd7, 32'h50, 1'b0, 32'h0);
      runCycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
      runIdle(1'b1, 32'h12345678);
      chk("rstreq_dmem_req", dmem_req, 1'b0);
      chk("rstreq_stall", stall_req, 1'b0);
      chk("rstreq_wb_we", wb_we, 1'b0);
      chk("rstreq_wb_rd", wb_rd, 5'd0);
      chk("rstreq_wb_data", wb_data, 32'h0);
      chk("rstreq_wb_pc", wb_pc, 32'h0);
      runIdle(1'b0, 32'h0);
      chk("rstreq_late_ready", wb_we, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int k;
         logic r, rdv, wr;
         logic [2:0] f3;
         logic [31:0] addr;
         k    = $urandom_range(0, 9);
         r    = ($urandom_range(0, 49) == 0);
         rdv  = (k >= 3 && k <= 5) || k == 9;
         wr   = (k >= 6);
         f3   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            if (rdv && !wr) f3 = ld_codes[$urandom_range(0, 4)];
            else            f3 = 3'($urandom_range(0, 2));
         end
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         runCycle(r, rdv, wr, 1'($urandom), f3, addr, $urandom, 5'($urandom),
                  $urandom, ($urandom_range(0, 1) == 1), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
